// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of retired stores that feeds the TCM write port.
// Optional load-overlap probe is enabled by defining STORE_BUFFER_CONFLICT_CHECK_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       commit_stbuf_push,
  input  logic [`ADDR_WIDTH-1:0]     commit_stbuf_addr,
  input  logic [`SIZE_WIDTH-1:0]     commit_stbuf_size,
  input  logic [`REG_DATA_WIDTH-1:0] commit_stbuf_data,
  output logic                       stbuf_commit_full,
  output logic [`ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  output logic [`SIZE_WIDTH-1:0]     stbuf_bus_write_size,
  output logic [`REG_DATA_WIDTH-1:0] stbuf_bus_write_data,
  output logic                       stbuf_bus_wr,
  input  logic                       bus_stbuf_write_ready,
  input  logic                       lsu_stbuf_query_valid,
  input  logic [`ADDR_WIDTH-1:0]     lsu_stbuf_query_addr,
  input  logic [`SIZE_WIDTH-1:0]     lsu_stbuf_query_size,
  output logic                       stbuf_lsu_conflict,
  output logic                       stbuf_empty
);

  localparam int unsigned AW    = `ADDR_WIDTH;
  localparam int unsigned SW    = `SIZE_WIDTH;
  localparam int unsigned DW    = `REG_DATA_WIDTH;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] size;
    logic [DW-1:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic             w_empty;
  logic             w_full;
  logic             w_size_ok;
  logic             w_push;
  logic             w_pop;
  entry_t           w_head_entry;

  // Extra wrap bit distinguishes full from empty when indices coincide.
  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_size_ok  = (commit_stbuf_size == SW'(1)) || (commit_stbuf_size == SW'(2)) ||
                      (commit_stbuf_size == SW'(4));
  assign w_push     = commit_stbuf_push && !w_full && w_size_ok;
  assign w_pop      = !w_empty && bus_stbuf_write_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
    end
  end

  // Payload storage needs no reset: validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[w_tail_idx] <= {commit_stbuf_addr, commit_stbuf_size, commit_stbuf_data};
    end
  end

  assign w_head_entry         = w_empty ? '0 : r_mem[w_head_idx];
  assign stbuf_bus_write_addr = w_head_entry.addr;
  assign stbuf_bus_write_size = w_head_entry.size;
  assign stbuf_bus_write_data = w_head_entry.data;
  assign stbuf_bus_wr         = !w_empty;
  assign stbuf_commit_full    = w_full;
  assign stbuf_empty          = w_empty;

`ifdef STORE_BUFFER_CONFLICT_CHECK_EN
  logic [PTR_W-1:0] w_count;
  logic [AW:0]      w_q_lo;
  logic [AW:0]      w_q_hi;
  logic [DEPTH-1:0] w_slot_hit;

  // One extra address bit keeps ranges near the top of memory from wrapping to 0.
  assign w_count = r_tail - r_head;
  assign w_q_lo  = {1'b0, lsu_stbuf_query_addr};
  assign w_q_hi  = w_q_lo + (AW+1)'(lsu_stbuf_query_size);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [IDX_W-1:0] w_off;
    logic [AW:0]      w_lo;
    logic [AW:0]      w_hi;
    assign w_off         = IDX_W'(g) - w_head_idx;
    assign w_lo          = {1'b0, r_mem[g].addr};
    assign w_hi          = w_lo + (AW+1)'(r_mem[g].size);
    assign w_slot_hit[g] = ({1'b0, w_off} < w_count) && (w_lo < w_q_hi) && (w_q_lo < w_hi);
  end

  assign stbuf_lsu_conflict = lsu_stbuf_query_valid && (lsu_stbuf_query_size != '0) &&
                              (|w_slot_hit);
`else
  logic w_unused_query;
  assign w_unused_query     = ^{lsu_stbuf_query_valid, lsu_stbuf_query_addr, lsu_stbuf_query_size};
  assign stbuf_lsu_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: queue-based reference model, directed
// scenarios followed by randomized traffic and resets.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
`ifdef STORE_BUFFER_CONFLICT_CHECK_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_stbuf_push;
  logic [31:0] commit_stbuf_addr;
  logic [2:0]  commit_stbuf_size;
  logic [31:0] commit_stbuf_data;
  logic        stbuf_commit_full;
  logic [31:0] stbuf_bus_write_addr;
  logic [2:0]  stbuf_bus_write_size;
  logic [31:0] stbuf_bus_write_data;
  logic        stbuf_bus_wr;
  logic        bus_stbuf_write_ready;
  logic        lsu_stbuf_query_valid;
  logic [31:0] lsu_stbuf_query_addr;
  logic [2:0]  lsu_stbuf_query_size;
  logic        stbuf_lsu_conflict;
  logic        stbuf_empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .commit_stbuf_push     (commit_stbuf_push),
    .commit_stbuf_addr     (commit_stbuf_addr),
    .commit_stbuf_size     (commit_stbuf_size),
    .commit_stbuf_data     (commit_stbuf_data),
    .stbuf_commit_full     (stbuf_commit_full),
    .stbuf_bus_write_addr  (stbuf_bus_write_addr),
    .stbuf_bus_write_size  (stbuf_bus_write_size),
    .stbuf_bus_write_data  (stbuf_bus_write_data),
    .stbuf_bus_wr          (stbuf_bus_wr),
    .bus_stbuf_write_ready (bus_stbuf_write_ready),
    .lsu_stbuf_query_valid (lsu_stbuf_query_valid),
    .lsu_stbuf_query_addr  (lsu_stbuf_query_addr),
    .lsu_stbuf_query_size  (lsu_stbuf_query_size),
    .stbuf_lsu_conflict    (stbuf_lsu_conflict),
    .stbuf_empty           (stbuf_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } st_t;

  st_t model_q[$];   // reference buffer contents, oldest first
  st_t exp_q[$];     // scoreboard of bus writes still expected
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-by-byte overlap over unbounded addresses, so no wrap aliasing.
  function automatic bit exp_conflict();
    if (!CONF_EN || !lsu_stbuf_query_valid) return 1'b0;
    foreach (model_q[k])
      for (int i = 0; i < int'(model_q[k].size); i++)
        for (int j = 0; j < int'(lsu_stbuf_query_size); j++)
          if (longint'(model_q[k].addr) + i == longint'(lsu_stbuf_query_addr) + j) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: updates on the same edge the DUT consumes inputs.
  always @(posedge clk) begin
    st_t e;
    bit  acc;
    if (!rst_n) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      acc = commit_stbuf_push && (model_q.size() < DEPTH) &&
            (commit_stbuf_size == 3'd1 || commit_stbuf_size == 3'd2 || commit_stbuf_size == 3'd4);
      if (model_q.size() > 0 && bus_stbuf_write_ready) void'(model_q.pop_front());
      if (acc) begin
        e.addr = commit_stbuf_addr;
        e.size = commit_stbuf_size;
        e.data = commit_stbuf_data;
        model_q.push_back(e);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares every cycle mid-period and retires accepted writes.
  always @(negedge clk) begin
    bit e_empty;
    e_empty = (model_q.size() == 0);
    chk("empty", 64'(stbuf_empty), 64'(e_empty));
    chk("full", 64'(stbuf_commit_full), 64'(model_q.size() == DEPTH));
    chk("bus_wr", 64'(stbuf_bus_wr), 64'(!e_empty));
    chk("conflict", 64'(stbuf_lsu_conflict), 64'(exp_conflict()));
    if (stbuf_bus_wr) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wr_unexpected: got write addr 0x%0h expected none at %0t",
                 stbuf_bus_write_addr, $time);
      end else begin
        chk("wr_addr", 64'(stbuf_bus_write_addr), 64'(exp_q[0].addr));
        chk("wr_size", 64'(stbuf_bus_write_size), 64'(exp_q[0].size));
        chk("wr_data", 64'(stbuf_bus_write_data), 64'(exp_q[0].data));
        if (bus_stbuf_write_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_outs", {stbuf_bus_write_addr, 29'(stbuf_bus_write_size), stbuf_bus_write_data[2:0]}, 64'd0);
    end
  end

  task automatic step(input bit p, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                      input bit rdy, input bit qv, input logic [31:0] qa, input logic [2:0] qs);
    commit_stbuf_push     = p;
    commit_stbuf_addr     = a;
    commit_stbuf_size     = s;
    commit_stbuf_data     = d;
    bus_stbuf_write_ready = rdy;
    lsu_stbuf_query_valid = qv;
    lsu_stbuf_query_addr  = qa;
    lsu_stbuf_query_size  = qs;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input bit rdy);
    step(1'b1, a, s, d, rdy, 1'b0, 32'd0, 3'd0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'd0, 3'd0, 32'd0, rdy, 1'b0, 32'd0, 3'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 2))
      0:       return 32'h100 + 32'($urandom_range(0, 12));
      1:       return 32'($urandom_range(0, 6));
      default: return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    logic [2:0] sizes [8];
    sizes = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};

    rst_n = 1'b0;
    idle(1'b0);
    idle(1'b0);
    rst_n = 1'b1;
    chk("rst_empty", 64'(stbuf_empty), 64'd1);
    chk("rst_bus_wr", 64'(stbuf_bus_wr), 64'd0);

    // Single store, latency one cycle, then drains.
    push(32'h100, 3'd4, 32'hDEAD_BEEF, 1'b1);
    chk("lat_bus_wr", 64'(stbuf_bus_wr), 64'd1);
    chk("lat_addr", 64'(stbuf_bus_write_addr), 64'h100);
    chk("lat_data", 64'(stbuf_bus_write_data), 64'hDEAD_BEEF);
    idle(1'b1);
    chk("lat_empty_after", 64'(stbuf_empty), 64'd1);

    // Fill while stalled; fifth push dropped; drain in order.
    for (int i = 0; i < 5; i++) begin
      push(32'h200 + 32'(4 * i), 3'd4, 32'hA000_0000 + 32'(i), 1'b0);
      if (i >= 3) chk("fill_full", 64'(stbuf_commit_full), 64'd1);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("fill_drained", 64'(stbuf_empty), 64'd1);

    // Push while full with a same-cycle pop: pop only.
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(i), 3'd1, 32'(i), 1'b0);
    push(32'h3F0, 3'd1, 32'h55, 1'b1);
    chk("full_pop_nofull", 64'(stbuf_commit_full), 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    push(32'h400, 3'd3, 32'h77, 1'b0);
    chk("badsize_empty", 64'(stbuf_empty), 64'd1);

    // Overlap probes including address wrap-around.
    push(32'h102, 3'd2, 32'h1234, 1'b0);
    step(1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 32'h100, 3'd4);
    chk("q_overlap", 64'(stbuf_lsu_conflict), 64'(CONF_EN));
    step(1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 32'h104, 3'd4);
    chk("q_adjacent", 64'(stbuf_lsu_conflict), 64'd0);
    idle(1'b1);
    push(32'hFFFF_FFFF, 3'd1, 32'hEE, 1'b0);
    step(1'b0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b1, 32'h0, 3'd1);
    chk("q_wrap", 64'(stbuf_lsu_conflict), 64'd0);
    idle(1'b1);

    // Reset mid-operation discards pending stores.
    for (int i = 0; i < 3; i++) push(32'h500 + 32'(4 * i), 3'd4, 32'(i), 1'b0);
    rst_n = 1'b0;
    step(1'b1, 32'h600, 3'd4, 32'h99, 1'b1, 1'b1, 32'h500, 3'd4);
    rst_n = 1'b1;
    chk("midrst_empty", 64'(stbuf_empty), 64'd1);
    chk("midrst_bus_wr", 64'(stbuf_bus_wr), 64'd0);
    chk("midrst_conflict", 64'(stbuf_lsu_conflict), 64'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      step($urandom_range(0, 9) < 7, rnd_addr(), sizes[$urandom_range(0, 7)], $urandom(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, rnd_addr(),
           sizes[$urandom_range(0, 5)]);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    chk("final_empty", 64'(stbuf_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
